// File: rtl/lcd_pixel_source.sv
// rtl/lcd_pixel_source.sv - raster-order RGB565 test-pattern source for the SPI LCD stage
//
// Produces one full frame of pixels (x fastest, then y) per streaming window,
// then idles for GAP_CYCLES clocks before the next frame if enable_i is still high.
//
// Ports:
//   clk_i            system clock
//   reset_i          synchronous reset, active-high
//   enable_i         level; 1 = keep generating frames
//   pattern_sel_i    0 solid, 1 colour bars, 2 gradient, 3 wipe
//   solid_color_i    RGB565 colour used by pattern 0
//   pix_data_o       RGB565 pixel
//   pix_valid_o      pix_data_o / pix_x_o / pix_y_o valid
//   pix_ready_i      downstream accepts when pix_valid_o & pix_ready_i
//   pix_x_o          x of presented pixel
//   pix_y_o          y of presented pixel
//   frame_start_o    high with pixel (0,0) while valid
//   frame_done_o     one-cycle pulse after the last pixel is accepted
//   frame_count_o    completed frames, wrapping
module lcd_pixel_source #(
    parameter int H_PIXELS   = 240,
    parameter int V_PIXELS   = 135,
    parameter int STEP_MAX   = 6,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [1:0]  pattern_sel_i,
    input  logic [15:0] solid_color_i,
    output logic [15:0] pix_data_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic [8:0]  pix_x_o,
    output logic [8:0]  pix_y_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic [15:0] frame_count_o
);

    localparam int              GW       = $clog2(GAP_CYCLES) + 1;
    localparam logic [8:0]      X_LAST   = 9'(H_PIXELS - 1);
    localparam logic [8:0]      Y_LAST   = 9'(V_PIXELS - 1);
    localparam logic [8:0]      H9       = 9'(H_PIXELS);
    localparam logic [8:0]      STEP9    = 9'(STEP_MAX);
    localparam logic [8:0]      BAR_W    = 9'(H_PIXELS / 8);
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic [8:0]     x_q, x_d;
    logic [8:0]     y_q, y_d;
    logic [15:0]    data_q, data_d;
    logic           fs_q, fs_d;
    logic           fd_q, fd_d;
    logic [15:0]    count_q, count_d;
    logic [8:0]     wpos_q, wpos_d;
    logic           wdir_q, wdir_d;     // 0 = up, 1 = down
    logic [8:0]     wstep_q, wstep_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [1:0]     pat_q, pat_d;
    logic [15:0]    solid_q, solid_d;
    logic           start_frame;

    function automatic logic [15:0] pixel_of(input logic [1:0]  pat,
                                             input logic [15:0] solid,
                                             input logic [8:0]  x,
                                             input logic [8:0]  y,
                                             input logic [8:0]  wpos);
        logic [8:0]  bar;
        logic [15:0] px;
        bar = x / BAR_W;
        if (bar > 9'd7) begin
            bar = 9'd7;
        end
        px = 16'h0000;
        case (pat)
            2'd0: px = solid;
            2'd1: begin
                case (bar[2:0])
                    3'd0:    px = 16'hFFFF;
                    3'd1:    px = 16'hFFE0;
                    3'd2:    px = 16'h07FF;
                    3'd3:    px = 16'h07E0;
                    3'd4:    px = 16'hF81F;
                    3'd5:    px = 16'hF800;
                    3'd6:    px = 16'h001F;
                    default: px = 16'h0000;
                endcase
            end
            2'd2:    px = {x[7:3], y[5:0], x[7:3]};
            default: px = (x < wpos) ? 16'h07E0 : 16'h001F;
        endcase
        return px;
    endfunction

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        x_d         = x_q;
        y_d         = y_q;
        data_d      = data_q;
        fs_d        = fs_q;
        fd_d        = 1'b0;
        count_d     = count_q;
        wpos_d      = wpos_q;
        wdir_d      = wdir_q;
        wstep_d     = wstep_q;
        gap_d       = gap_q;
        pat_d       = pat_q;
        solid_d     = solid_q;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    start_frame = 1'b1;
                end
            end
            S_STREAM: begin
                if (valid_q && pix_ready_i) begin
                    fs_d = 1'b0;
                    if (x_q != X_LAST) begin
                        x_d = x_q + 9'd1;
                    end else if (y_q != Y_LAST) begin
                        x_d = 9'd0;
                        y_d = y_q + 9'd1;
                    end else begin
                        state_d = S_GAP;
                        valid_d = 1'b0;
                        x_d     = 9'd0;
                        y_d     = 9'd0;
                        fd_d    = 1'b1;
                        count_d = count_q + 16'd1;
                        gap_d   = '0;
                        // Compare before add/sub so the 9-bit position never wraps.
                        if (!wdir_q) begin
                            if (wpos_q >= H9 - wstep_q) begin
                                wpos_d = H9;
                                wdir_d = 1'b1;
                            end else begin
                                wpos_d = wpos_q + wstep_q;
                            end
                        end else begin
                            if (wpos_q <= wstep_q) begin
                                wpos_d  = 9'd0;
                                wdir_d  = 1'b0;
                                wstep_d = (wstep_q == STEP9) ? 9'd1 : wstep_q + 9'd1;
                            end else begin
                                wpos_d = wpos_q - wstep_q;
                            end
                        end
                    end
                    // Next pixel is precomputed so pix_data stays a register output.
                    data_d = pixel_of(pat_q, solid_q, x_d, y_d, wpos_q);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (enable_i) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pattern and colour are sampled only here, so mid-frame changes are ignored.
        if (start_frame) begin
            state_d = S_STREAM;
            valid_d = 1'b1;
            x_d     = 9'd0;
            y_d     = 9'd0;
            fs_d    = 1'b1;
            pat_d   = pattern_sel_i;
            solid_d = solid_color_i;
            data_d  = pixel_of(pattern_sel_i, solid_color_i, 9'd0, 9'd0, wpos_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            x_q     <= 9'd0;
            y_q     <= 9'd0;
            data_q  <= 16'h0000;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            count_q <= 16'h0000;
            wpos_q  <= 9'd0;
            wdir_q  <= 1'b0;
            wstep_q <= 9'd1;
            gap_q   <= '0;
            pat_q   <= 2'd0;
            solid_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            count_q <= count_d;
            wpos_q  <= wpos_d;
            wdir_q  <= wdir_d;
            wstep_q <= wstep_d;
            gap_q   <= gap_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
        end
    end

    assign pix_data_o    = data_q;
    assign pix_valid_o   = valid_q;
    assign pix_x_o       = x_q;
    assign pix_y_o       = y_q;
    assign frame_start_o = fs_q;
    assign frame_done_o  = fd_q;
    assign frame_count_o = count_q;

endmodule

// File: tb/tb_lcd_pixel_source.sv
// tb/tb_lcd_pixel_source.sv - directed self-checking bench for lcd_pixel_source
module tb_lcd_pixel_source;

    localparam int H = 240;
    localparam int V = 135;

    logic        clk;
    logic        reset, enable, pix_ready;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic [8:0]  pix_x, pix_y;
    logic        frame_start, frame_done;
    logic [15:0] frame_count;

    logic        s_reset, s_enable, s_ready;
    logic [1:0]  s_pattern;
    logic [15:0] s_solid;
    logic [15:0] s_data;
    logic        s_valid;
    logic [8:0]  s_x, s_y;
    logic        s_fs, s_fd;
    logic [15:0] s_count;

    int tests;
    int fails;
    int bad;
    int frame_pixels;
    logic [15:0] row0 [0:239];

    lcd_pixel_source u_dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (enable),
        .pattern_sel_i (pattern_sel),
        .solid_color_i (solid_color),
        .pix_data_o    (pix_data),
        .pix_valid_o   (pix_valid),
        .pix_ready_i   (pix_ready),
        .pix_x_o       (pix_x),
        .pix_y_o       (pix_y),
        .frame_start_o (frame_start),
        .frame_done_o  (frame_done),
        .frame_count_o (frame_count)
    );

    lcd_pixel_source #(
        .H_PIXELS   (16),
        .V_PIXELS   (2),
        .STEP_MAX   (3),
        .GAP_CYCLES (1)
    ) u_small (
        .clk_i         (clk),
        .reset_i       (s_reset),
        .enable_i      (s_enable),
        .pattern_sel_i (s_pattern),
        .solid_color_i (s_solid),
        .pix_data_o    (s_data),
        .pix_valid_o   (s_valid),
        .pix_ready_i   (s_ready),
        .pix_x_o       (s_x),
        .pix_y_o       (s_y),
        .frame_start_o (s_fs),
        .frame_done_o  (s_fd),
        .frame_count_o (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int pat, input logic [15:0] solid,
                                            input int x, input int y, input int wpos);
        int         bar;
        logic [8:0] xv;
        logic [8:0] yv;
        xv  = 9'(x);
        yv  = 9'(y);
        bar = x / (H / 8);
        if (bar > 7) bar = 7;
        if (pat == 0) return solid;
        if (pat == 2) return {xv[7:3], yv[5:0], xv[7:3]};
        if (pat == 3) return (x < wpos) ? 16'h07E0 : 16'h001F;
        case (bar)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Entered at a negedge where pixel (0,0) should be presented. act_kind 1 changes the
    // pattern and drops enable at (act_x,act_y); act_kind 2 asserts reset there and returns.
    task automatic stream_frame(input int pat, input logic [15:0] solid, input int wpos,
                                input int rand_until, input int act_kind,
                                input int act_x, input int act_y, input string tag);
        int ex, ey, n, cyc;
        int bad_data, bad_xy, bad_fs, bad_valid, bad_hold, bad_fd;
        logic        held, rdy, hfs;
        logic [15:0] hd;
        logic [8:0]  hx, hy;
        ex = 0; ey = 0; n = 0; cyc = 0;
        bad_data = 0; bad_xy = 0; bad_fs = 0; bad_valid = 0; bad_hold = 0; bad_fd = 0;
        held = 1'b0; hd = '0; hx = '0; hy = '0; hfs = 1'b0;
        while (n < H * V && cyc < 34000) begin
            cyc++;
            if (!pix_valid) begin
                bad_valid++;
            end else begin
                if (held && (pix_data !== hd || pix_x !== hx || pix_y !== hy || frame_start !== hfs))
                    bad_hold++;
                if (pix_x !== 9'(ex) || pix_y !== 9'(ey)) bad_xy++;
                if (pix_data !== exp_pix(pat, solid, ex, ey, wpos)) bad_data++;
                if (frame_start !== (ex == 0 && ey == 0)) bad_fs++;
                if (ey == 0) row0[ex] = pix_data;
            end
            if (frame_done !== 1'b0) bad_fd++;
            if (act_kind == 2 && ex == act_x && ey == act_y) begin
                reset     = 1'b1;
                pix_ready = 1'b1;
                break;
            end
            if (act_kind == 1 && ex == act_x && ey == act_y) begin
                pattern_sel = 2'd2;
                enable      = 1'b0;
            end
            rdy = (n < rand_until) ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_ready = rdy;
            if (pix_valid && rdy) begin
                n++;
                held = 1'b0;
                if (ex == H - 1) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
            end else begin
                held = pix_valid;
                hd   = pix_data;
                hx   = pix_x;
                hy   = pix_y;
                hfs  = frame_start;
            end
            @(negedge clk);
        end
        frame_pixels = n;
        check({tag, "_data"},     bad_data,  0);
        check({tag, "_xy"},       bad_xy,    0);
        check({tag, "_fstart"},   bad_fs,    0);
        check({tag, "_valid"},    bad_valid, 0);
        check({tag, "_stall"},    bad_hold,  0);
        check({tag, "_fdone_mid"}, bad_fd,   0);
    endtask

    task automatic measure_gap(input string tag);
        int g, fd_seen;
        g = 0;
        fd_seen = 0;
        while (!pix_valid && g < 100) begin
            if (frame_done) fd_seen++;
            g++;
            @(negedge clk);
        end
        check({tag, "_gap_len"}, g, 16);
        check({tag, "_fdone_once"}, fd_seen, 1);
    endtask

    initial begin
        int wp, wd, ws, green, w;
        tests = 0;
        fails = 0;
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_color = 16'h0000; pix_ready = 1'b0;
        s_reset = 1'b1; s_enable = 1'b0; s_pattern = 2'd3; s_solid = 16'h0000; s_ready = 1'b0;

        // Reset, then idle with enable low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        check("rst_fstart", frame_start, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_count", frame_count, 0);
        reset = 1'b0;
        s_reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, frame_count} !== '0) bad++;
        end
        check("idle_outputs_zero", bad, 0);

        // Frame 1: solid red, ready always high.
        pattern_sel = 2'd0; solid_color = 16'hF800; pix_ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        check("f1_first_valid", pix_valid, 1);
        check("f1_first_fstart", frame_start, 1);
        stream_frame(0, 16'hF800, 0, 0, 0, 0, 0, "f1");
        check("f1_pixels", frame_pixels, H * V);
        check("f1_fdone", frame_done, 1);
        check("f1_count", frame_count, 1);
        check("f1_valid_after", pix_valid, 0);
        pattern_sel = 2'd1;
        solid_color = 16'h1234;
        measure_gap("f1");

        // Frame 2: colour bars with a random-stall stretch; pattern change and enable drop mid-frame.
        check("f2_first_fstart", frame_start, 1);
        check("f2_first_x", pix_x, 0);
        stream_frame(1, 16'h1234, 1, 600, 1, 100, 50, "f2");
        check("f2_pixels", frame_pixels, H * V);
        check("f2_bar_x29", row0[29], 16'hFFFF);
        check("f2_bar_x30", row0[30], 16'hFFE0);
        check("f2_bar_x239", row0[239], 16'h0000);
        check("f2_fdone", frame_done, 1);
        check("f2_count", frame_count, 2);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pix_valid !== 1'b0) bad++;
        end
        check("f2_stays_idle", bad, 0);

        // Frame 3: wipe at position 2, reset at (120,60).
        pattern_sel = 2'd3;
        enable = 1'b1;
        @(negedge clk);
        check("f3_first_valid", pix_valid, 1);
        stream_frame(3, 16'h0000, 2, 0, 2, 120, 60, "f3");
        check("f3_wipe_x1", row0[1], 16'h07E0);
        check("f3_wipe_x2", row0[2], 16'h001F);
        @(negedge clk);
        check("f3_rst_valid", pix_valid, 0);
        check("f3_rst_x", pix_x, 0);
        check("f3_rst_y", pix_y, 0);
        check("f3_rst_count", frame_count, 0);
        check("f3_rst_fstart", frame_start, 0);
        reset = 1'b0;
        @(negedge clk);
        check("f4_restart_valid", pix_valid, 1);
        check("f4_restart_fstart", frame_start, 1);
        check("f4_restart_x", pix_x, 0);
        check("f4_restart_y", pix_y, 0);
        check("f4_restart_data", pix_data, 16'h001F);
        enable = 1'b0;
        pix_ready = 1'b0;

        // Wipe progression on the small instance (16x2, step max 3, 1-cycle gap).
        s_enable = 1'b1;
        s_ready = 1'b1;
        wp = 0; wd = 0; ws = 1;
        for (int f = 0; f < 40; f++) begin
            w = 0;
            while (!s_valid && w < 10) begin
                w++;
                @(negedge clk);
            end
            green = 0;
            bad = 0;
            for (int p = 0; p < 32; p++) begin
                if (!s_valid || s_x !== 9'(p % 16) || s_y !== 9'(p / 16)) bad++;
                if (s_data !== (((p % 16) < wp) ? 16'h07E0 : 16'h001F)) bad++;
                if (p < 16 && s_data === 16'h07E0) green++;
                @(negedge clk);
            end
            check("wipe_green", green, wp);
            check("wipe_pixels", bad, 0);
            check("wipe_count", s_count, f + 1);
            if (wd == 0) begin
                if (wp + ws >= 16) begin
                    wp = 16;
                    wd = 1;
                end else begin
                    wp = wp + ws;
                end
            end else begin
                if (wp - ws <= 0) begin
                    wp = 0;
                    wd = 0;
                    ws = (ws == 3) ? 1 : ws + 1;
                end else begin
                    wp = wp - ws;
                end
            end
        end
        s_enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
